byte_stream_fetch: RTL and testbench
====================================

// Module: byte_stream_fetch
// PURPOSE
//  - Bytecode front end for the JIT. Fetches aligned words from instruction RAM and
//    buffers them in a word FIFO. Serialises them MSB-first, one byte per handshake,
//    to the bytecode decoder.
//  - Successor to the single-PC word fetcher: parametrised width and depth, prefetch
//    buffering, unaligned start, and redirect (branch) with flush of in-flight data.
// PARAMETERS
//  - ADDRESS_WIDTH  8   byte-address width; the PC wraps modulo 2**ADDRESS_WIDTH
//  - WORD_BYTES     4   bytes per memory word; power of 2, >=2
//  - FIFO_DEPTH     4   prefetch buffer depth in words; power of 2, >=2
// PORTS
//  - clk            in   1        clock, rising edge
//  - pc_reset       in   1        reset, asynchronous, active-low
//  - pc_reset_value in   AW       start byte address, sampled while pc_reset==0
//  - mem_req        out  1        word fetch request; held until acked
//  - mem_addr       out  AW       word-aligned fetch address (low log2(WORD_BYTES) bits = 0)
//  - mem_ack        in   1        fetch done this cycle; mem_data valid this cycle
//  - mem_data       in   8*WB     fetched word; byte 0 = MSB (big-endian, JVM order)
//  - redirect       in   1        load new PC (branch); synchronous, single-cycle
//  - redirect_pc    in   AW       new byte address; may be unaligned
//  - byte_valid     out  1        byte_data/byte_pc valid
//  - byte_ready     in   1        consumer accepts the byte when byte_valid & byte_ready
//  - byte_data      out  8        current bytecode byte
//  - byte_pc        out  AW       byte address of byte_data
// BEHAVIOUR
//  - Reset values: mem_req=0, byte_valid=0, byte_data=0.
//    byte_pc=pc_reset_value. mem_addr=pc_reset_value & ~(WB-1).
//    FIFO empty; state IDLE.
//  - FSM:
//    - IDLE -> REQ on the first clk after reset release.
//    - REQ: mem_req=1. Moves to FULL when no free slot remains for the next word.
//    - FULL -> REQ when a slot frees.
//    - DROP: entered when redirect occurs while mem_req=1. A write is pending on ack.
//  - Fetch: at most one outstanding request.
//    - mem_addr/mem_req stay stable until mem_ack.
//    - On ack the word is pushed and mem_addr += WB, wrapping 0xFC -> 0x00 for AW=8.
//    - In the same cycle, mem_req stays 1 when another slot is free.
//  - Byte output: byte_data = byte (byte_pc % WB) of the FIFO head.
//    - On accept, byte_pc += 1.
//    - The head word pops when the last byte (offset WB-1) is accepted.
//  - Unaligned start (reset or redirect): the leading bytes of the first word are
//    skipped; the first presented byte is at the given address.
//  - Redirect: takes priority over a same-cycle accept and a same-cycle ack.
//    - FIFO flushed; byte_valid=0 next cycle. byte_pc=redirect_pc.
//    - mem_addr is set to the aligned redirect_pc.
//    - An outstanding request is not cancelled. Its ack is absorbed (data discarded,
//      DROP -> REQ), then the new address is issued.
//  - Latency: redirect/reset-release to first byte_valid = 2 cycles + memory latency.
//  - Full: at most FIFO_DEPTH words are held.
//    - Pop and ack in the same cycle are both performed.
//    - No overflow is possible; the slot count includes the outstanding request.
//  - Empty: byte_valid=0; byte_ready is ignored.
//  - Reset mid-fetch: everything returns to reset values immediately. A late mem_ack
//    is ignored while in IDLE.
// CONFIGURATION
//  - BYTE_STREAM_PEEK_EN defined: adds peek_valid (out 1) and peek_data (out 16).
//    These carry the two bytes following byte_data (operand fetch).
//    - peek_valid=1 only when both bytes are buffered; they may span two FIFO words.
//    - Adds input byte_skip (in 2): on accept, byte_pc advances by 1+byte_skip,
//      with byte_skip <= 2. Words pop as they are crossed.
//  - Not defined: none of these ports exist; advance is always 1.
// STRUCTURE
//  - Shared package byte_fetch_pkg holds:
//    - BYTE_W=8 and the OFFS_W=$clog2(WORD_BYTES) function.
//    - FSM state typedef/encodings IDLE/REQ/FULL/DROP.
//  - Sub-module word_fifo (DEPTH, WIDTH): synchronous push/pop, flush, count,
//    async active-low reset.
//  - Top level: FSM, address counter, byte selector.
// TESTING
//  1. Reset value 0x00, RAM 0x00..0x0F holds bytes 0x10..0x1F, 1-cycle ack.
//     Response: bytes 0x10..0x1F stream in order, byte_pc 0..15.
//  2. Reset value 0x06, same RAM -> first byte 0x16 at byte_pc 6; mem_addr starts at 0x04.
//  3. byte_ready=0 for 20 cycles -> mem_req drops after 4 words are buffered.
//     Then ready=1 -> no byte is lost or duplicated.
//  4. Redirect to 0x21 while a request is outstanding with 3-cycle ack latency.
//     Response: stale word dropped, next byte is RAM[0x21], byte_pc=0x21.
//  5. Start 0xFC, AW=8 -> after 0xFF, mem_addr wraps to 0x00 and byte_pc to 0x00.
//  6. PEEK_EN: word 0xB6_00_05_xx with skip=2 on the 0xB6 accept.
//     Response: peek=0x0005 beforehand; byte_pc advances by 3.

Source files
------------

// File: rtl/byte_fetch_pkg.sv
// Shared types and constants for the bytecode fetch front end.
package byte_fetch_pkg;

    localparam int unsigned BYTE_W = 8;

    // Width of the byte-offset-within-word field.
    function automatic int unsigned offs_w(input int unsigned word_bytes);
        return $clog2(word_bytes);
    endfunction

    // Fetch FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFull = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/word_fifo.sv
// Prefetch word FIFO: synchronous push/pop with flush. pop may retire up to
// two words in one cycle. Exposes the head word and the word after it.
module word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     pc_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [1:0]               pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      count_q;

    // Storage write; entries need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Read ports.
    always_comb begin
        head_data = mem_q[rd_ptr_q];
        next_data = mem_q[rd_ptr_q + PW'(1)];
        count     = count_q;
    end

endmodule

// File: rtl/byte_stream_fetch.sv
// Bytecode fetch front end: fetches aligned words into a prefetch FIFO and
// serialises them MSB-first, one byte per handshake. Redirect flushes buffered
// data; an outstanding fetch is drained and discarded before the new address.
// Optional feature macro: BYTE_STREAM_PEEK_EN (operand peek + multi-byte skip).
module byte_stream_fetch
    import byte_fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned WORD_BYTES    = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          pc_reset,
    input  logic [ADDRESS_WIDTH-1:0]      pc_reset_value,
    output logic                          mem_req,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    input  logic                          mem_ack,
    input  logic [BYTE_W*WORD_BYTES-1:0]  mem_data,
    input  logic                          redirect,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [BYTE_W-1:0]             byte_data,
    output logic [ADDRESS_WIDTH-1:0]      byte_pc
`ifdef BYTE_STREAM_PEEK_EN
    ,
    input  logic [1:0]                    byte_skip,
    output logic                          peek_valid,
    output logic [15:0]                   peek_data
`endif
);

    localparam int unsigned AW     = ADDRESS_WIDTH;
    localparam int unsigned OFFS_W = offs_w(WORD_BYTES);
    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W  = OFFS_W + 1;
    localparam int unsigned SUM_W  = OFFS_W + 2;

    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        r[OFFS_W-1:0] = '0;
        return r;
    endfunction

    // Byte idx of the concatenated {head, next} pair, byte 0 = MSB of head.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [2*WORD_W-1:0] pair,
                                                    input logic [IDX_W-1:0] idx);
        logic [2*WORD_W-1:0] sh;
        sh = pair << (BYTE_W * idx);
        return sh[2*WORD_W-1 -: BYTE_W];
    endfunction

    fetch_state_e       state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      pc_q, pc_d;

    logic               push, flush, accept;
    logic [1:0]         pop_n;
    logic [1:0]         adv_m1;
    logic [SUM_W-1:0]   off_sum;
    logic [OFFS_W-1:0]  offset;
    logic [CNT_W-1:0]   fifo_count, level_after_pop;
    logic [WORD_W-1:0]  head_word, next_word;
    logic [2*WORD_W-1:0] pair;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_word_fifo (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop_n),
        .flush     (flush),
        .head_data (head_word),
        .next_data (next_word),
        .count     (fifo_count)
    );

    // Byte presentation from the FIFO head at the current PC offset.
    always_comb begin
        offset     = pc_q[OFFS_W-1:0];
        pair       = {head_word, next_word};
        byte_valid = (fifo_count != '0);
        byte_data  = byte_valid ? pick_byte(pair, {1'b0, offset}) : '0;
        byte_pc    = pc_q;
        mem_addr   = addr_q;
        mem_req    = (state_q == StReq) || (state_q == StDrop);
    end

`ifdef BYTE_STREAM_PEEK_EN
    logic [CNT_W+OFFS_W-1:0] buffered;
    logic [IDX_W-1:0]        idx1, idx2;

    // Operand peek: the two bytes after byte_data, possibly straddling words.
    always_comb begin
        buffered   = {fifo_count, {OFFS_W{1'b0}}} - (CNT_W + OFFS_W)'(offset);
        idx1       = {1'b0, offset} + IDX_W'(1);
        idx2       = {1'b0, offset} + IDX_W'(2);
        peek_valid = (fifo_count != '0) && (buffered >= (CNT_W + OFFS_W)'(3));
        peek_data  = peek_valid ? {pick_byte(pair, idx1), pick_byte(pair, idx2)} : '0;
        adv_m1     = byte_skip;
    end
`else
    // Without peek the stream always advances by exactly one byte.
    always_comb begin
        adv_m1 = 2'd0;
    end
`endif

    // Consumer advance: words pop as the byte pointer crosses them.
    always_comb begin
        accept          = byte_valid && byte_ready && !redirect;
        off_sum         = SUM_W'(offset) + SUM_W'(adv_m1) + SUM_W'(1);
        pop_n           = accept ? off_sum[OFFS_W +: 2] : 2'd0;
        level_after_pop = fifo_count - CNT_W'(pop_n);
    end

    // Fetch FSM, address counter and PC next-state; redirect overrides all.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // Outstanding request already owns a slot, so a push never overflows.
                if (mem_ack) begin
                    push    = 1'b1;
                    addr_d  = addr_q + AW'(WORD_BYTES);
                    state_d = (level_after_pop < CNT_W'(FIFO_DEPTH - 1)) ? StReq : StFull;
                end
            end
            StFull: begin
                if (level_after_pop < CNT_W'(FIFO_DEPTH)) begin
                    state_d = StReq;
                end
            end
            StDrop: begin
                // Stale word is discarded; mem_addr already holds the new target.
                if (mem_ack) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            pc_d = pc_q + AW'(adv_m1) + AW'(1);
        end

        if (redirect) begin
            push    = 1'b0;
            flush   = 1'b1;
            pc_d    = redirect_pc;
            addr_d  = align_addr(redirect_pc);
            // A same-cycle ack closes the old request, so nothing is left to drain.
            state_d = (mem_req && !mem_ack) ? StDrop : StReq;
        end
    end

    // State registers; reset loads the start PC.
    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q <= StIdle;
            addr_q  <= align_addr(pc_reset_value);
            pc_q    <= pc_reset_value;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_byte_stream_fetch.sv
// Scoreboard bench for byte_stream_fetch: a RAM model answers fetches, each
// (re)start loads the expected byte stream, and a monitor checks every accept.
module tb_byte_stream_fetch;

    localparam int AW = 8;
    localparam int WB = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         pc_reset = 1'b0;
    logic [7:0]   pc_reset_value = 8'h00;
    logic         mem_req;
    logic [7:0]   mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_data = '0;
    logic         redirect = 1'b0;
    logic [7:0]   redirect_pc = 8'h00;
    logic         byte_valid;
    logic         byte_ready = 1'b0;
    logic [7:0]   byte_data;
    logic [7:0]   byte_pc;
`ifdef BYTE_STREAM_PEEK_EN
    logic [1:0]   byte_skip = 2'd0;
    logic         peek_valid;
    logic [15:0]  peek_data;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ram [256];
    int vectors = 0;
    int miscompares = 0;
    int n_accept = 0;
    int ack_count = 0;
    int lat_wait = 0;
    int ready_mode = 0;

    byte_stream_fetch #(
        .ADDRESS_WIDTH (AW),
        .WORD_BYTES    (WB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .pc_reset       (pc_reset),
        .pc_reset_value (pc_reset_value),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .byte_data      (byte_data),
        .byte_pc        (byte_pc)
`ifdef BYTE_STREAM_PEEK_EN
        ,
        .byte_skip      (byte_skip),
        .peek_valid     (peek_valid),
        .peek_data      (peek_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endfunction

    // Reference stream: consecutive byte addresses mod 256 from the start PC.
    task automatic load_expected(input logic [7:0] start);
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] p;
            p = start + 8'(i);
            exp_q.push_back(exp_t'({ram[p], p}));
        end
    endtask

    // Memory model: ack after lat_wait extra cycles, data from the address
    // latched when the request was first seen.
    initial begin
        logic [7:0] req_addr;
        int wait_cnt;
        req_addr = 8'h00;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                if (pc_reset) ack_count++;
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (!pc_reset) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    req_addr = mem_addr;
                    check("mem_addr aligned", 32'(mem_addr[1:0]), 32'd0);
                end
                wait_cnt++;
                if (wait_cnt > lat_wait) begin
                    mem_ack  = 1'b1;
                    mem_data = {ram[req_addr], ram[8'(req_addr + 8'd1)],
                                ram[8'(req_addr + 8'd2)], ram[8'(req_addr + 8'd3)]};
                end
            end
        end
    end

    // Consumer: ready pattern selected by ready_mode (0 stall, 1 always, 2 random).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            byte_ready = (ready_mode == 1) ? 1'b1 :
                         (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef BYTE_STREAM_PEEK_EN
            byte_skip = !peek_valid ? 2'd0 :
                        (byte_pc == 8'h80) ? 2'd2 : 2'($urandom_range(0, 2));
`endif
        end
    end

    // Monitor: every accepted byte is popped off the scoreboard and compared.
    always @(negedge clk) begin
        if (pc_reset && byte_valid && byte_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL stream: got byte 0x%0h pc 0x%0h, want nothing queued",
                         byte_data, byte_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("stream {data,pc}", 32'({byte_data, byte_pc}), 32'({e.d, e.pc}));
`ifdef BYTE_STREAM_PEEK_EN
                if (peek_valid && exp_q.size() >= 2) begin
                    check("peek_data", 32'(peek_data), 32'({exp_q[0].d, exp_q[1].d}));
                end
                for (int k = 0; k < int'(byte_skip); k++) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
`endif
            end
            n_accept++;
        end
    end

    task automatic do_reset(input logic [7:0] start);
        @(posedge clk);
        #2;
        pc_reset       = 1'b0;
        pc_reset_value = start;
        redirect       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset byte_valid", 32'(byte_valid), 32'd0);
        check("reset byte_data", 32'(byte_data), 32'd0);
        check("reset byte_pc", 32'(byte_pc), 32'(start));
        check("reset mem_addr", 32'(mem_addr), 32'(start & 8'hFC));
        load_expected(start);
        ack_count = 0;
        @(posedge clk);
        #2;
        pc_reset = 1'b1;
    endtask

    task automatic redirect_now(input logic [7:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        load_expected(pc);
        @(posedge clk);
        #2;
        redirect = 1'b0;
        @(negedge clk);
        check("byte_valid after redirect", 32'(byte_valid), 32'd0);
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        @(posedge clk);
        #2;
        redirect_now(pc);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int target;
        target = n_accept + n;
        for (int c = 0; c < budget && n_accept < target; c++) @(posedge clk);
        check("bytes delivered in budget", 32'(n_accept >= target), 32'd1);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 256; i++) ram[i] = (i < 16) ? 8'(i + 16) : 8'($urandom);
        ram[8'h21] = 8'h5A;
        ram[8'h80] = 8'hB6;
        ram[8'h81] = 8'h00;
        ram[8'h82] = 8'h05;

        // Aligned start, single-cycle memory, first-byte latency.
        lat_wait   = 0;
        ready_mode = 1;
        do_reset(8'h00);
        @(posedge clk);
        @(negedge clk);
        check("latency not yet valid", 32'(byte_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency valid", 32'(byte_valid), 32'd1);
        wait_bytes(16, 100);

        // Unaligned start.
        do_reset(8'h06);
        wait_bytes(10, 100);

        // Consumer stall fills the buffer, then drains without loss.
        ready_mode = 0;
        do_reset(8'h00);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall mem_req", 32'(mem_req), 32'd0);
        check("stall words fetched", 32'(ack_count), 32'(DEPTH));
        check("stall byte_valid", 32'(byte_valid), 32'd1);
        ready_mode = 1;
        wait_bytes(20, 200);

        // Redirect during an outstanding slow fetch.
        lat_wait   = 2;
        ready_mode = 2;
        do_reset(8'h40);
        begin
            int c;
            for (c = 0; c < 50; c++) begin
                @(posedge clk);
                #2;
                if (mem_req && !mem_ack) break;
            end
            check("outstanding request seen", 32'(c < 50), 32'd1);
        end
        redirect_now(8'h21);
        wait_bytes(8, 300);

        // Address wrap.
        lat_wait   = 0;
        ready_mode = 1;
        do_reset(8'hFC);
        wait_bytes(12, 100);

        // Operand word at 0x80 exercises peek/skip when enabled.
        redirect_to(8'h80);
        wait_bytes(4, 100);

        // Randomised latency, backpressure, redirects and resets.
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            lat_wait = $urandom_range(0, 3);
            repeat ($urandom_range(5, 40)) @(posedge clk);
            r = $urandom_range(0, 9);
            if (r == 0) do_reset(8'($urandom));
            else if (r < 6) redirect_to(8'($urandom));
        end
        ready_mode = 1;
        wait_bytes(8, 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
